// File: rtl/alu_seq_unit.sv
// ALU with funct decode, a registered execute stage and iterative shift/multiply behind start/busy/done.
// Optional macro ALU_SEQ_MUL_EN builds the shift-add multiplier; without it funct 1001 decodes as invalid.
module alu_seq_unit #(
    parameter int WIDTH      = 24,
    parameter int SHW        = 5,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             invalid
);
    localparam int MAXIT = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
    localparam int CW    = $clog2(MAXIT + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    typedef enum logic [3:0] {
        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_XOR, OP_SLT, OP_SLL, OP_SRL, OP_MUL, OP_INV
    } op_t;

    state_t           state, next_state;
    op_t              dec_op, op_r;
    logic [WIDTH-1:0] opa;
    logic [CW-1:0]    cnt, sh_amt;
    logic [31:0]      sh_raw;
    logic [WIDTH-1:0] sum, diff, single_res, iter_res;
    logic             single_ovf, accept, to_iter, last_iter;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] acc, opb;
`endif

    always_comb begin
        dec_op = OP_INV;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct)
                    4'b0000: dec_op = OP_AND;
                    4'b0001: dec_op = OP_OR;
                    4'b0010: dec_op = OP_ADD;
                    4'b0011: dec_op = OP_SUB;
                    4'b0100: dec_op = OP_NOR;
                    4'b0101: dec_op = OP_XOR;
                    4'b0110: dec_op = OP_SLT;
                    4'b0111: dec_op = OP_SLL;
                    4'b1000: dec_op = OP_SRL;
                    4'b1001: begin
`ifdef ALU_SEQ_MUL_EN
                        dec_op = OP_MUL;
`else
                        dec_op = OP_INV;
`endif
                    end
                    default: dec_op = OP_INV;
                endcase
            end
            default: dec_op = OP_INV;
        endcase
    end

    // Shift amounts at or beyond the word width all collapse to exactly WIDTH iterations.
    always_comb begin
        sh_raw = 32'(B[SHW-1:0]);
        sh_amt = (sh_raw >= 32'(WIDTH)) ? CW'(WIDTH) : CW'(sh_raw);
    end

    always_comb begin
        sum        = A + B;
        diff       = A - B;
        single_res = '0;
        single_ovf = 1'b0;
        case (dec_op)
            OP_AND: single_res = A & B;
            OP_OR:  single_res = A | B;
            OP_ADD: begin
                single_res = sum;
                single_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                single_res = diff;
                single_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_NOR: single_res = ~(A | B);
            OP_XOR: single_res = A ^ B;
            OP_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL, OP_SRL: single_res = A;
            default: single_res = '0;
        endcase
    end

    assign accept    = (state == IDLE) && start;
    assign to_iter   = (((dec_op == OP_SLL) || (dec_op == OP_SRL)) && (sh_amt != '0))
                       || (dec_op == OP_MUL);
    assign last_iter = (state == ITER) && (cnt == CW'(1));

    // Value the working registers take on the current iteration, committed to result on the last one.
    always_comb begin
        iter_res = '0;
        case (op_r)
            OP_SLL: iter_res = opa << 1;
            OP_SRL: iter_res = opa >> 1;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: iter_res = opb[0] ? (acc + opa) : acc;
`endif
            default: iter_res = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) next_state = to_iter ? ITER : DONE;
            ITER: begin
                busy = 1'b1;
                if (last_iter) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operands are captured at accept so later input changes cannot disturb an in-flight operation.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_r    <= OP_INV;
            opa     <= '0;
            cnt     <= '0;
            result  <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            invalid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc     <= '0;
            opb     <= '0;
`endif
        end else if (accept) begin
            op_r <= dec_op;
            opa  <= A;
            cnt  <= (dec_op == OP_MUL) ? CW'(MUL_CYCLES) : sh_amt;
`ifdef ALU_SEQ_MUL_EN
            acc  <= '0;
            opb  <= B;
`endif
            if (!to_iter) begin
                result  <= single_res;
                zero    <= (single_res == '0);
                ovf     <= single_ovf;
                invalid <= (dec_op == OP_INV);
            end
        end else if (state == ITER) begin
            opa <= (op_r == OP_SRL) ? (opa >> 1) : (opa << 1);
            cnt <= cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
            if (op_r == OP_MUL) begin
                acc <= iter_res;
                opb <= opb >> 1;
            end
`endif
            if (last_iter) begin
                result  <= iter_res;
                zero    <= (iter_res == '0);
                ovf     <= 1'b0;
                invalid <= 1'b0;
            end
        end
    end
endmodule
